// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish in one cycle; MUL is a fixed-latency shift-add over WIDTH cycles.
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Z,
  output logic             N,
  output logic             V
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam int unsigned MSB = WIDTH - 1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             v_q, v_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic [WIDTH-1:0] acc_sum;

  // Single-cycle datapath on the live operands; only used on the accept edge.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (ALUop)
      OP_ADD: begin
        alu_res = Ain + Bin;
        alu_v   = (Ain[MSB] == Bin[MSB]) && (alu_res[MSB] != Ain[MSB]);
      end
      OP_SUB: begin
        alu_res = Ain - Bin;
        alu_v   = (Ain[MSB] != Bin[MSB]) && (alu_res[MSB] != Ain[MSB]);
      end
      OP_AND:  alu_res = Ain & Bin;
      OP_NOT:  alu_res = ~Bin;
      OP_OR:   alu_res = Ain | Bin;
      OP_XOR:  alu_res = Ain ^ Bin;
      OP_PASS: alu_res = Ain;
      default: alu_res = '0;
    endcase
  end

  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state and register-load decode.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (ALUop == OP_MUL) begin
            mcand_d  = Ain;
            mplier_d = Bin;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            out_d   = alu_res;
            z_d     = (alu_res == '0);
            n_d     = alu_res[MSB];
            v_d     = alu_v;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Last of WIDTH iterations: no early exit so latency stays fixed.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          out_d   = acc_sum;
          z_d     = (acc_sum == '0);
          n_d     = acc_sum[MSB];
          v_d     = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      z_q         <= z_d;
      n_q         <= n_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out       = out_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign V         = v_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results, negedge monitor pops and compares.
module tb_alu_seq;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic [2:0]       ALUop;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             Z;
  logic             N;
  logic             V;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .Z(Z), .N(N), .V(V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        v;
    int          lat;
    int          acc_edge;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdy_mode = 1;
  logic        seen = 1'b0;
  logic [18:0] held;

  always @(posedge clk) cyc++;

  // Consumer: 0 random, 1 always ready, 2 stalled.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = ($urandom % 3) != 0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic on integers.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    int     sa, sb, s;
    longint p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    e.v = 1'b0;
    e.acc_edge = 0;
    case (op)
      3'd0: begin s = sa + sb; e.res = 16'(s); e.v = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; e.res = 16'(s); e.v = (s > 32767) || (s < -32768); end
      3'd2: e.res = a & b;
      3'd3: e.res = ~b;
      3'd4: e.res = a | b;
      3'd5: e.res = a ^ b;
      3'd6: begin p = longint'(a) * longint'(b); e.res = 16'(p); end
      default: e.res = a;
    endcase
    e.z   = (e.res == 16'h0);
    e.n   = e.res[15];
    e.lat = (op == 3'd6) ? WIDTH + 1 : 1;
    return e;
  endfunction

  // Monitor: first cycle of out_valid checks against the scoreboard, later cycles check hold.
  always @(negedge clk) begin
    if (!reset) begin
      if (!out_valid) begin
        seen = 1'b0;
      end else begin
        chk("in_ready_while_valid", 32'(in_ready), 32'd0);
        if (!seen) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("out", 32'(out), 32'(e.res));
            chk("Z", 32'(Z), 32'(e.z));
            chk("N", 32'(N), 32'(e.n));
            chk("V", 32'(V), 32'(e.v));
            chk("latency", 32'(cyc - e.acc_edge + 1), 32'(e.lat));
          end
          held = {out, Z, N, V};
          seen = 1'b1;
        end else begin
          chk("hold_stable", 32'({out, Z, N, V}), 32'(held));
        end
      end
    end
  end

  task automatic garbage();
    in_valid = 1'($urandom % 2);
    Ain      = 16'($urandom);
    Bin      = 16'($urandom);
    ALUop    = 3'($urandom);
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      garbage();
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("issue_timeout", 32'd1, 32'd0);
      return;
    end
    in_valid = 1'b1;
    Ain = a;
    Bin = b;
    ALUop = op;
    e = model(op, a, b);
    e.acc_edge = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    garbage();
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    @(negedge clk);
    while ((q.size() != 0 || out_valid) && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain_done", 32'(q.size() != 0 || out_valid), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out"}, 32'(out), 32'd0);
    chk({tag, "_flags"}, 32'({Z, N, V}), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    in_valid = 1'b0;
    Ain = '0;
    Bin = '0;
    ALUop = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;

    // Directed cases.
    rdy_mode = 1;
    issue(3'd0, 16'h7FFF, 16'h0001);
    issue(3'd1, 16'h0005, 16'h0005);
    issue(3'd0, 16'h0001, 16'h0001);
    issue(3'd6, 16'h0003, 16'h0005);
    issue(3'd6, 16'h0100, 16'h0100);
    issue(3'd3, 16'h1234, 16'h00FF);
    issue(3'd5, 16'hAAAA, 16'hFFFF);
    issue(3'd1, 16'h8000, 16'h0001);
    issue(3'd6, 16'hFFFF, 16'hFFFF);
    issue(3'd7, 16'hBEEF, 16'h0000);
    drain();

    // Backpressure with busy-side input churn.
    rdy_mode = 2;
    issue(3'd4, 16'h1200, 16'h0034);
    n = 0;
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1;
      Ain = 16'($urandom);
      Bin = 16'($urandom);
      ALUop = 3'($urandom);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Randomised traffic with random consumer stalls.
    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom), 16'($urandom), 16'($urandom));
    end
    rdy_mode = 1;
    drain();

    // Reset in the middle of a multiply.
    issue(3'd6, 16'h1357, 16'h2468);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("mid_mul_reset");
    q.delete();
    reset = 1'b0;
    issue(3'd0, 16'h0002, 16'h0003);
    drain();

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
